// File: rtl/memory_fifo_pkg.sv
// Shared constants and helpers for the memory-backed show-ahead FIFO controller.
package memory_fifo_pkg;

  localparam int ADDRESS_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF    = 32;
  localparam int DEPTH             = 2 ** ADDRESS_WIDTH_DEF;
  localparam int PTR_W             = ADDRESS_WIDTH_DEF + 1;
  localparam int LVL_W             = ADDRESS_WIDTH_DEF + 2;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  // One extra pointer bit separates full (count==DEPTH) from empty.
  function automatic int ptr_w(input int aw);
    return aw + 1;
  endfunction

  // Level spans 0..DEPTH+1 because the prefetched head lives outside the RAM.
  function automatic int lvl_w(input int aw);
    return aw + 2;
  endfunction

  typedef struct packed {
    logic push;
    logic fetch;
    logic pop_only;
  } fifo_ev_t;

endpackage

// File: rtl/memory_fifo_ctrl_ptr.sv
// Wrapping AW+1-bit pointer: async active-low reset, synchronous clear, increment.
module fifo_ptr
  import memory_fifo_pkg::*;
#(
  parameter int W = ptr_w(ADDRESS_WIDTH_DEF)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/memory_fifo_ctrl.sv
// Show-ahead FIFO controller driving a 1-cycle-latency simple dual-port memory;
// the head word is held in the memory's dataOut register.
module memory_fifo_ctrl
  import memory_fifo_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_data,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH+1:0] level,
  output logic                     mem_WR,
  output logic [ADDRESS_WIDTH-1:0] mem_wraddr,
  output logic [DATA_WIDTH-1:0]    mem_dataIn,
  output logic                     mem_RD,
  output logic [ADDRESS_WIDTH-1:0] mem_rdaddr,
  input  logic [DATA_WIDTH-1:0]    mem_dataOut
);

  localparam int FDEPTH = depth_of(ADDRESS_WIDTH);
  localparam int PW     = ptr_w(ADDRESS_WIDTH);
  localparam int LW     = lvl_w(ADDRESS_WIDTH);

  // Handshakes: a word moves on a rising edge where valid && ready are both
  // high (and flush is low); valid never depends on ready, ready and valid
  // from this block are registered, and dropped offers leave no trace.

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] mem_count;
  logic [PW-1:0] mem_count_next;
  logic          out_valid_next;
  logic [LW-1:0] level_next;
  fifo_ev_t      ev;

  assign mem_count = wr_ptr - rd_ptr;

  // Fetch only from slots written at an earlier edge, so WR and RD never collide.
  always_comb begin
    ev          = '0;
    ev.push     = in_valid && in_ready && !flush;
    ev.fetch    = (mem_count != '0) && (!out_valid || out_ready) && !flush;
    ev.pop_only = out_valid && out_ready && !ev.fetch && !flush;
  end

  always_comb begin
    mem_count_next = '0;
    out_valid_next = 1'b0;
    if (!flush) begin
      mem_count_next = mem_count + PW'(ev.push) - PW'(ev.fetch);
      if (ev.fetch) begin
        out_valid_next = 1'b1;
      end else if (ev.pop_only) begin
        out_valid_next = 1'b0;
      end else begin
        out_valid_next = out_valid;
      end
    end
  end

  assign level_next = LW'(mem_count_next) + LW'(out_valid_next);

  fifo_ptr #(.W(PW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (ev.push),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.W(PW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (ev.fetch),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      level     <= '0;
    end else begin
      in_ready  <= (mem_count_next < PW'(FDEPTH)) && !flush;
      out_valid <= out_valid_next;
      level     <= level_next;
    end
  end

  assign mem_WR     = ev.push;
  assign mem_wraddr = wr_ptr[ADDRESS_WIDTH-1:0];
  assign mem_dataIn = in_data;
  assign mem_RD     = ev.fetch;
  assign mem_rdaddr = rd_ptr[ADDRESS_WIDTH-1:0];
  assign out_data   = mem_dataOut;

endmodule

// File: tb/tb_memory_fifo_ctrl.sv
// Directed and random bench for memory_fifo_ctrl with a behavioural 1-cycle dual-port memory.
module tb_memory_fifo_ctrl;

  localparam int AW    = 2;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LW    = AW + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [LW-1:0] level;
  logic          mem_WR;
  logic [AW-1:0] mem_wraddr;
  logic [DW-1:0] mem_dataIn;
  logic          mem_RD;
  logic [AW-1:0] mem_rdaddr;
  logic [DW-1:0] mem_dataOut;

  logic [DW-1:0] ram [DEPTH];

  int total = 0;
  int bad = 0;
  int pops = 0;
  int accepted;
  int p0;
  logic [DW-1:0] exp_q[$];

  memory_fifo_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .level       (level),
    .mem_WR      (mem_WR),
    .mem_wraddr  (mem_wraddr),
    .mem_dataIn  (mem_dataIn),
    .mem_RD      (mem_RD),
    .mem_rdaddr  (mem_rdaddr),
    .mem_dataOut (mem_dataOut)
  );

  // clock / memory model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_WR) ram[mem_wraddr] <= mem_dataIn;
    if (mem_RD) mem_dataOut <= ram[mem_rdaddr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score the handshakes seen before the edge, then check level.
  task automatic cycle();
    logic          do_push;
    logic          do_pop;
    logic          do_flush;
    logic [DW-1:0] exp_w;
    do_flush = flush;
    do_push  = in_valid && in_ready && !flush;
    do_pop   = out_valid && out_ready && !flush;
    if (do_pop) begin
      check("pop_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        check("out_data", out_data, exp_w);
        pops++;
      end
    end
    if (do_push) exp_q.push_back(in_data);
    @(posedge clk);
    #1;
    if (do_flush) exp_q.delete();
    check("level", level, exp_q.size());
  endtask

  task automatic drain(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && level != 0; i++) cycle();
    check(tag, level, 0);
    check({tag, "_q"}, exp_q.size(), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    // reset held with a pushing producer
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h1111_1111;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_mem_wr", mem_WR, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_level", level, 0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", in_ready, 1);

    // single word, held under backpressure
    in_valid  = 1'b1;
    in_data   = 32'hDEAD_BEEF;
    out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    check("sw_not_yet", out_valid, 0);
    cycle();
    check("sw_valid", out_valid, 1);
    check("sw_data", out_data, 32'hDEAD_BEEF);
    repeat (5) begin
      cycle();
      check("sw_hold_valid", out_valid, 1);
      check("sw_hold_data", out_data, 32'hDEAD_BEEF);
      check("sw_level", level, 1);
    end
    drain("sw_drain");

    // fill to DEPTH+1, sixth word dropped
    accepted  = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      if (in_ready) accepted++;
      cycle();
    end
    in_valid = 1'b0;
    check("fill_accepted", accepted, 5);
    check("fill_in_ready", in_ready, 0);
    check("fill_level", level, 5);
    check("fill_head", out_data, 0);
    p0 = pops;
    drain("fill_drain");
    check("fill_pops", pops - p0, 5);

    // streaming with pointer wrap
    in_valid  = 1'b1;
    out_ready = 1'b1;
    p0 = pops;
    for (int i = 0; i < 20; i++) begin
      in_data = 32'h100 + DW'(i);
      cycle();
      if (i >= 1) check("stream_valid", out_valid, 1);
      check("stream_level_range", (level >= 1) && (level <= 2), 1);
    end
    check("stream_pops", pops - p0, 18);
    drain("stream_drain");

    // random valid/ready
    for (int i = 0; i < 2000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      cycle();
    end
    drain("rand_drain");

    // flush with three words held
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'hA0 + DW'(i);
      cycle();
    end
    check("pre_flush_level", level, 3);
    flush   = 1'b1;
    in_data = 32'hBAD0_BAD0;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_level", level, 0);
    check("flush_in_ready", in_ready, 0);
    cycle();
    check("flush_in_ready_back", in_ready, 1);
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = 32'hC0 + DW'(i);
      cycle();
    end
    p0 = pops;
    drain("post_flush_drain");
    check("post_flush_pops", pops - p0, 2);

    // asynchronous reset mid-cycle
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'hD0 + DW'(i);
      cycle();
    end
    in_valid = 1'b0;
    check("pre_rst_level", level, 3);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_level", level, 0);
    check("arst_in_ready", in_ready, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_in_ready_back", in_ready, 1);
    in_valid = 1'b1;
    in_data  = 32'hE0E0_E0E0;
    cycle();
    p0 = pops;
    drain("post_rst_drain");
    check("post_rst_pops", pops - p0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
